// File: rtl/div_result_display_if.sv
// Handshake bundle between the integer divider and its result display:
// the divider's completion strobe and operands, and the BCD/display outputs.
interface div_result_display_if #(
   parameter int WIDTH = 4
);
   logic             done;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic             busy;
   logic             valid;
   logic [7:0]       q_bcd;
   logic [7:0]       r_bcd;
   logic [3:0]       an;
   logic [6:0]       seg;

   modport master (
      output done, quo, rem,
      input  busy, valid, q_bcd, r_bcd, an, seg
   );

   modport slave (
      input  done, quo, rem,
      output busy, valid, q_bcd, r_bcd, an, seg
   );
endinterface

// File: rtl/div_result_display.sv
// Captures the divider's quotient/remainder, converts both to BCD with serial
// double dabble, and scans them onto a 4-digit multiplexed seven-segment display.
module div_result_display #(
   parameter int WIDTH    = 4,
   parameter int SCAN_DIV = 50000
) (
   input  logic                 clk,
   input  logic                 rst,
   div_result_display_if.slave  bus
);
   localparam int SCAN_W = $clog2(SCAN_DIV);
   localparam int CNT_W  = $clog2(WIDTH + 1);

   generate
      if (WIDTH < 1 || WIDTH > 6) begin : g_bad_width
         $error("div_result_display: WIDTH must be in 1..6");
      end
      if (SCAN_DIV < 2) begin : g_bad_scan
         $error("div_result_display: SCAN_DIV must be at least 2");
      end
   endgenerate

   typedef enum logic {IDLE, CONV} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              busy_r;
   logic              valid_r;
   logic [7:0]        q_bcd_r;
   logic [7:0]        r_bcd_r;
   logic [WIDTH-1:0]  q_sr;
   logic [WIDTH-1:0]  r_sr;
   logic [7:0]        q_acc;
   logic [7:0]        r_acc;
   logic [7:0]        q_adj;
   logic [7:0]        r_adj;
   logic [7:0]        q_shift;
   logic [7:0]        r_shift;

   logic [SCAN_W-1:0] scan_cnt;
   logic [1:0]        idx;
   logic [1:0]        idx_nxt;
   logic [3:0]        digit;
   logic              blank;
   logic [3:0]        an_r;
   logic [6:0]        seg_r;

   // Nibbles are corrected independently; no carry crosses a nibble boundary.
   function automatic logic [7:0] add3(input logic [7:0] acc);
      logic [3:0] lo;
      logic [3:0] hi;
      lo = acc[3:0];
      hi = acc[7:4];
      if (lo >= 4'd5) lo = lo + 4'd3;
      if (hi >= 4'd5) hi = hi + 4'd3;
      return {hi, lo};
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   assign q_adj   = add3(q_acc);
   assign r_adj   = add3(r_acc);
   assign q_shift = {q_adj[6:0], q_sr[WIDTH-1]};
   assign r_shift = {r_adj[6:0], r_sr[WIDTH-1]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         busy_r  <= 1'b0;
         valid_r <= 1'b0;
         q_bcd_r <= 8'h00;
         r_bcd_r <= 8'h00;
      end else begin
         valid_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.done) begin
                  state  <= CONV;
                  busy_r <= 1'b1;
                  cnt    <= CNT_W'(WIDTH);
               end
            end
            CONV: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state   <= IDLE;
                  busy_r  <= 1'b0;
                  valid_r <= 1'b1;
                  q_bcd_r <= q_shift;
                  r_bcd_r <= r_shift;
               end
            end
         endcase
      end
   end

   // Shift datapath carries no reset; the FSM alone decides when it is meaningful.
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.done) begin
         q_sr  <= bus.quo;
         r_sr  <= bus.rem;
         q_acc <= 8'h00;
         r_acc <= 8'h00;
      end else if (state == CONV) begin
         q_sr  <= q_sr << 1;
         r_sr  <= r_sr << 1;
         q_acc <= q_shift;
         r_acc <= r_shift;
      end
   end

   assign idx_nxt = idx + 2'd1;

   always_comb begin
      digit = 4'd0;
      case (idx_nxt)
         2'd0: digit = r_bcd_r[3:0];
         2'd1: digit = r_bcd_r[7:4];
         2'd2: digit = q_bcd_r[3:0];
         2'd3: digit = q_bcd_r[7:4];
      endcase
   end

   // Odd indices are tens digits, which blank when zero.
   assign blank = idx_nxt[0] && (digit == 4'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt <= '0;
         idx      <= 2'd0;
         an_r     <= 4'b1110;
         seg_r    <= 7'b1000000;
      end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         idx      <= idx_nxt;
         an_r     <= ~(4'b0001 << idx_nxt);
         seg_r    <= blank ? 7'b1111111 : seg7(digit);
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   assign bus.busy  = busy_r;
   assign bus.valid = valid_r;
   assign bus.q_bcd = q_bcd_r;
   assign bus.r_bcd = r_bcd_r;
   assign bus.an    = an_r;
   assign bus.seg   = seg_r;
endmodule

// File: tb/tb_div_result_display.sv
// Bench for div_result_display: two instances (WIDTH 4 and 6) driven with directed
// and random conversions, checked against an arithmetic BCD/scan model.
module tb_div_result_display;
   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   div_result_display_if #(.WIDTH(4)) if4 ();
   div_result_display_if #(.WIDTH(6)) if6 ();

   div_result_display #(.WIDTH(4), .SCAN_DIV(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
   div_result_display #(.WIDTH(6), .SCAN_DIV(3)) u6 (.clk(clk), .rst(rst), .bus(if6));

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;
   int ncyc    = 0;
   int exp_q4, exp_r4, exp_q6, exp_r6;
   logic [6:0] seg_tbl [10];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   function automatic logic [3:0] exp_an(input int k, input int s);
      case ((k / s) % 4)
         0:       return 4'b1110;
         1:       return 4'b1101;
         2:       return 4'b1011;
         default: return 4'b0111;
      endcase
   endfunction

   function automatic logic [6:0] exp_seg(input int k, input int s, input int q, input int r);
      int ix, d;
      ix = (k / s) % 4;
      case (ix)
         0:       d = r % 10;
         1:       d = r / 10;
         2:       d = q % 10;
         default: d = q / 10;
      endcase
      if ((ix % 2) == 1 && d == 0) return 7'b1111111;
      return seg_tbl[d];
   endfunction

   function automatic logic get_busy(input bit w6);
      return w6 ? if6.busy : if4.busy;
   endfunction
   function automatic logic get_valid(input bit w6);
      return w6 ? if6.valid : if4.valid;
   endfunction
   function automatic logic [7:0] get_q(input bit w6);
      return w6 ? if6.q_bcd : if4.q_bcd;
   endfunction
   function automatic logic [7:0] get_r(input bit w6);
      return w6 ? if6.r_bcd : if4.r_bcd;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
      ncyc++;
   endtask

   task automatic drive(input bit w6, input logic d, input int q, input int r);
      if (w6) begin
         if6.done = d;
         if6.quo  = 6'(q);
         if6.rem  = 6'(r);
      end else begin
         if4.done = d;
         if4.quo  = 4'(q);
         if4.rem  = 4'(r);
      end
   endtask

   task automatic conv(input bit w6, input int q, input int r);
      int w;
      w = w6 ? 6 : 4;
      drive(w6, 1'b1, q, r);
      tick;
      drive(w6, 1'b0, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      for (int c = 1; c <= w; c++) begin
         chk($sformatf("busy_c%0d_w%0d", c, w), get_busy(w6), 1);
         chk($sformatf("valid_c%0d_w%0d", c, w), get_valid(w6), 0);
         tick;
      end
      chk($sformatf("valid_w%0d_q%0d", w, q), get_valid(w6), 1);
      chk($sformatf("busy_end_w%0d", w), get_busy(w6), 0);
      chk($sformatf("q_bcd_w%0d_q%0d", w, q), get_q(w6), bcd(q));
      chk($sformatf("r_bcd_w%0d_r%0d", w, r), get_r(w6), bcd(r));
      if (w6) begin exp_q6 = q; exp_r6 = r; end
      else    begin exp_q4 = q; exp_r4 = r; end
      tick;
      chk($sformatf("valid_clear_w%0d", w), get_valid(w6), 0);
   endtask

   task automatic scan_chk(input int n);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("an4_k%0d", ncyc), if4.an, exp_an(ncyc, 4));
         chk($sformatf("seg4_k%0d", ncyc), if4.seg, exp_seg(ncyc, 4, exp_q4, exp_r4));
         chk($sformatf("an6_k%0d", ncyc), if6.an, exp_an(ncyc, 3));
         chk($sformatf("seg6_k%0d", ncyc), if6.seg, exp_seg(ncyc, 3, exp_q6, exp_r6));
         tick;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      exp_q4 = 0; exp_r4 = 0; exp_q6 = 0; exp_r6 = 0;
      drive(1'b0, 1'b0, 0, 0);
      drive(1'b1, 1'b0, 0, 0);
      repeat (3) tick;

      chk("rst_busy", if4.busy, 0);
      chk("rst_valid", if4.valid, 0);
      chk("rst_q_bcd", if4.q_bcd, 8'h00);
      chk("rst_r_bcd", if4.r_bcd, 8'h00);
      chk("rst_an", if4.an, 4'b1110);
      chk("rst_seg", if4.seg, 7'b1000000);
      chk("rst_an6", if6.an, 4'b1110);

      rst  = 1'b1;
      ncyc = 0;
      scan_chk(20);

      conv(1'b0, 13, 2);

      // Second done mid-conversion is ignored; done in the valid cycle is accepted.
      drive(1'b0, 1'b1, 13, 2);
      tick;
      drive(1'b0, 1'b0, 0, 0);
      tick;
      drive(1'b0, 1'b1, 9, 1);
      tick;
      drive(1'b0, 1'b0, 0, 0);
      tick;
      tick;
      chk("ign_valid", if4.valid, 1);
      chk("ign_q_bcd", if4.q_bcd, 8'h13);
      chk("ign_r_bcd", if4.r_bcd, 8'h02);
      drive(1'b0, 1'b1, 9, 1);
      tick;
      drive(1'b0, 1'b0, 0, 0);
      chk("acc_busy", if4.busy, 1);
      chk("acc_valid0", if4.valid, 0);
      repeat (4) tick;
      chk("acc_valid", if4.valid, 1);
      chk("acc_q_bcd", if4.q_bcd, 8'h09);
      chk("acc_r_bcd", if4.r_bcd, 8'h01);
      exp_q4 = 9; exp_r4 = 1;
      tick;

      for (int i = 0; i < 6; i++)
         conv(1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      for (int i = 0; i < 6; i++)
         conv(1'b1, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));

      conv(1'b1, 63, 59);
      conv(1'b1, 0, 37);
      conv(1'b0, 15, 0);
      repeat (20) tick;
      scan_chk(24);

      // Reset pulse in cycle 3 of a conversion, also mid-scan.
      drive(1'b0, 1'b1, 11, 7);
      tick;
      drive(1'b0, 1'b0, 0, 0);
      tick;
      tick;
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", if4.busy, 0);
      chk("mid_rst_valid", if4.valid, 0);
      chk("mid_rst_q_bcd", if4.q_bcd, 8'h00);
      chk("mid_rst_r_bcd", if4.r_bcd, 8'h00);
      chk("mid_rst_an", if4.an, 4'b1110);
      chk("mid_rst_seg", if4.seg, 7'b1000000);
      chk("mid_rst_q6", if6.q_bcd, 8'h00);
      chk("mid_rst_an6", if6.an, 4'b1110);
      #2;
      rst  = 1'b1;
      ncyc = 0;
      exp_q4 = 0; exp_r4 = 0; exp_q6 = 0; exp_r6 = 0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("post_rst_valid_%0d", i), if4.valid, 0);
         chk($sformatf("post_rst_busy_%0d", i), if4.busy, 0);
         chk($sformatf("post_rst_q_%0d", i), if4.q_bcd, 8'h00);
         chk($sformatf("post_rst_r_%0d", i), if4.r_bcd, 8'h00);
         tick;
      end
      scan_chk(20);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/div_result_display.md
# div_result_display

Downstream consumer of the integer divider's control/datapath. On the divider's `done` pulse it captures the quotient and remainder and converts both to BCD by serial shift-add-3 (double dabble). It publishes the BCD result with a one-cycle `valid` strobe and continuously drives a 4-digit multiplexed seven-segment display showing quotient (left pair) and remainder (right pair).

## Interface

Parameters:
- `WIDTH`, default 4: width of quotient and remainder. Legal range is 1..6, so the maximum value is 63 (two BCD digits). Any other value must fail elaboration.
- `SCAN_DIV`, default 50000: clocks per display digit. Must be ≥2. The scan counter is `$clog2(SCAN_DIV)` bits.

Ports:
- `clk` in 1: single clock; all state is updated on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `done` in 1: divider completion strobe; high for one cycle.
- `quo` in WIDTH: quotient; valid while `done`=1.
- `rem` in WIDTH: remainder; valid while `done`=1.
- `busy` out 1: high while a conversion is in progress.
- `valid` out 1: one-cycle strobe when `q_bcd`/`r_bcd` update.
- `q_bcd` out 8: quotient BCD, {tens, ones}.
- `r_bcd` out 8: remainder BCD, {tens, ones}.
- `an` out 4: digit enables, active-low, one-hot.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.

## Operation

Conversion FSM, registered, two states:
- IDLE: `busy`=0.
  - If `done`=1 at the clock edge: capture `quo`/`rem` into shift registers, clear both 8-bit BCD accumulators, load `cnt`=WIDTH, and go to CONV.
- CONV: `busy`=1. `done` is ignored.
  - Each edge: for each accumulator nibble ≥5, add 3 (combinational, per nibble). Then shift left by one, taking the capture register MSB into the accumulator LSB. Decrement `cnt`.
  - On the edge where `cnt`=1 (the last shift): load the shifted accumulators into `q_bcd`/`r_bcd`, set `valid`=1, and go to IDLE.
- `valid` is a registered strobe. It clears on the next edge unconditionally.
- The nibble correction never carries across nibbles; with WIDTH≤6 no nibble exceeds 9 after the final shift.

Display scan (free-running and independent of the FSM):
- The scan counter counts 0..SCAN_DIV-1 and wraps. On wrap, digit index `idx` advances 0→1→2→3→0.
- `an`: `idx`0=4'b1110 (r ones), 1=4'b1101 (r tens), 2=4'b1011 (q ones), 3=4'b0111 (q tens).
- `seg` decodes the selected nibble from the published `q_bcd`/`r_bcd` only, never from the accumulators:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles >9 show 7'b1111111 (unreachable).
- Leading-zero blanking: a tens digit of 0 shows 7'b1111111. Ones digits always display.
- `an` and `seg` are registered and update on the same edge as `idx`.

Reset (`rst`=0, asynchronous, any state):
- FSM goes to IDLE.
- `busy`=0, `valid`=0, `q_bcd`=8'h00, `r_bcd`=8'h00.
- Scan counter=0, `idx`=0, `an`=4'b1110, `seg`=7'b1000000.
- A conversion interrupted by reset is discarded: no `valid` and no output update.

## Timing

- Cycle numbering: `done`=1 in cycle 0 (IDLE).
- `busy`=1 in cycles 1..WIDTH.
- `valid`=1 in cycle WIDTH+1; the new `q_bcd`/`r_bcd` are visible in that cycle; `busy`=0.
- Latency from the `done` cycle to `valid` is WIDTH+1 cycles (5 at the default width).
- `done`=1 in the `valid` cycle is accepted: IDLE captures, and `busy`=1 next cycle.
- `q_bcd`/`r_bcd` hold between updates. The display switches to new values at its next scan register update after `valid`.
- Display period is 4×SCAN_DIV clocks. Each digit is shown for exactly SCAN_DIV clocks.

## Test plan

- **Reset:** assert `rst`=0 mid-scan and mid-CONV → all outputs immediately at their reset values (`an`=1110, `seg`=1000000, `busy`=0, `valid`=0); release → scan restarts at `idx`=0.
- **Basic conversion:** WIDTH=4, `quo`=13, `rem`=2, `done` pulse in cycle 0 → `busy` in cycles 1..4; `valid` in cycle 5 with `q_bcd`=8'h13, `r_bcd`=8'h02; `valid`=0 in cycle 6.
- **Display decode:** SCAN_DIV=4, result `quo`=15, `rem`=0 → `an` steps 1110/1101/1011/0111 every 4 clocks; `seg` = 1000000, 1111111 (blanked tens), 0010010, 1111001.
- **Done during conversion:** WIDTH=4, a second `done` with `quo`=9 in cycle 2 → ignored, result still 8'h13. `done` with `quo`=9, `rem`=1 in the `valid` cycle → accepted; next `valid` 5 cycles later with `q_bcd`=8'h09, `r_bcd`=8'h01.
- **Reset mid-conversion:** pulse `rst` low in cycle 3 → no `valid`, `q_bcd`/`r_bcd` remain 8'h00.
- **Maximum width:** WIDTH=6, `quo`=63, `rem`=59 → `valid` in cycle 7, `q_bcd`=8'h63, `r_bcd`=8'h59; `quo`=0 → 8'h00 with q tens blanked.
